// File: rtl/bus_reg_bank.sv
// Bank of C-bus written, B-bus read datapath registers with per-register
// increment, first-write valid flags and wrap detection.
module bus_reg_bank #(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 4,
    parameter int CW        = 4,
    parameter int BW        = 3,
    parameter int CBUS_BASE = 4,
    parameter int BBUS_BASE = 4,
    parameter int SEL_W     = 2,
    parameter int STEP      = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    cbus_out,
    input  logic [CW-1:0]       cbus_en,
    input  logic [BW-1:0]       bbus_en,
    input  logic                inc_en,
    input  logic [SEL_W-1:0]    inc_sel,
    output logic [WIDTH-1:0]    bbus_in,
    output logic                bbus_hit,
    output logic [NUM_REGS-1:0] reg_valid,
    output logic                inc_wrap
);

    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num
        $error("bus_reg_bank: NUM_REGS must be 1..16");
    end
    if (CBUS_BASE + NUM_REGS - 1 >= (1 << CW)) begin : g_bad_cbus
        $error("bus_reg_bank: C-bus codes exceed cbus_en range");
    end
    if (BBUS_BASE + NUM_REGS - 1 >= (1 << BW)) begin : g_bad_bbus
        $error("bus_reg_bank: B-bus codes exceed bbus_en range");
    end
    if ((1 << SEL_W) < NUM_REGS) begin : g_bad_sel
        $error("bus_reg_bank: inc_sel too narrow for NUM_REGS");
    end

    logic [WIDTH-1:0]    regs     [NUM_REGS];
    logic [WIDTH:0]      sum      [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] inc_take;
    logic                wrap_next;

    // A write to the same register drops the increment and its wrap.
    always_comb begin
        wrap_next = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i]   = (cbus_en == CW'(CBUS_BASE + i));
            inc_take[i] = inc_en && (inc_sel == SEL_W'(i)) && !wr_hit[i];
            sum[i]      = {1'b0, regs[i]} + (WIDTH+1)'(STEP);
            if (inc_take[i] && sum[i][WIDTH]) begin
                wrap_next = 1'b1;
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_valid <= '0;
            inc_wrap  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    regs[i]      <= cbus_out;
                    reg_valid[i] <= 1'b1;
                end else if (inc_take[i]) begin
                    regs[i] <= sum[i][WIDTH-1:0];
                end
            end
            inc_wrap <= wrap_next;
        end
    end

    // Zero when not selected so several banks can be OR-ed onto the B-bus.
    always_comb begin
        bbus_in  = '0;
        bbus_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bbus_en == BW'(BBUS_BASE + i)) begin
                bbus_in  = regs[i];
                bbus_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_reg_bank.sv
// Scoreboard bench for bus_reg_bank: directed scenarios then random traffic,
// checked against an array-based reference model.
`timescale 1ns/1ps
module tb_bus_reg_bank;

    logic        clock;
    logic        reset;
    logic [31:0] cbus_out;
    logic [3:0]  cbus_en;
    logic [2:0]  bbus_en;
    logic        inc_en;
    logic [2:0]  inc_sel;
    logic [31:0] bbus_in;
    logic        bbus_hit;
    logic [3:0]  reg_valid;
    logic        inc_wrap;

    bus_reg_bank #(
        .WIDTH(32), .NUM_REGS(4), .CW(4), .BW(3),
        .CBUS_BASE(4), .BBUS_BASE(4), .SEL_W(3), .STEP(1)
    ) dut (
        .clock(clock), .reset(reset), .cbus_out(cbus_out),
        .cbus_en(cbus_en), .bbus_en(bbus_en), .inc_en(inc_en),
        .inc_sel(inc_sel), .bbus_in(bbus_in), .bbus_hit(bbus_hit),
        .reg_valid(reg_valid), .inc_wrap(inc_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rd;
        logic        hit;
        logic [3:0]  valid;
        logic        wrap;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m [4];
    bit   [3:0]  mv;
    bit          mw;

    // Posedge is idle for the DUT; inputs go in at +1, checks happen at +3,
    // and the DUT updates on the falling edge at +5.
    task automatic cycle(input bit rst, input bit rel, input logic [3:0] ce,
                         input logic [31:0] d, input logic [2:0] be,
                         input bit ie, input logic [2:0] is, input string tag);
        exp_t e;
        int   w;
        longint unsigned s;
        @(posedge clock);
        #1;
        reset    = rst;
        cbus_en  = ce;
        cbus_out = d;
        bbus_en  = be;
        inc_en   = ie;
        inc_sel  = is;
        if (rst) begin
            for (int i = 0; i < 4; i++) m[i] = '0;
            mv = '0;
            mw = 1'b0;
        end
        e.rd    = (be >= 4) ? m[be - 4] : 32'd0;
        e.hit   = (be >= 4);
        e.valid = mv;
        e.wrap  = mw;
        e.tag   = tag;
        q.push_back(e);
        if (rst && rel) begin
            #3;
            reset = 1'b0;
        end
        if (!(rst && !rel)) begin
            w = (ce >= 4 && ce <= 7) ? int'(ce) - 4 : -1;
            if (w >= 0) begin
                m[w]  = d;
                mv[w] = 1'b1;
            end
            mw = 1'b0;
            if (ie && is < 4 && int'(is) != w) begin
                s  = {32'd0, m[is]} + 64'd1;
                mw = (s > 64'h0000_0000_FFFF_FFFF);
                m[is] = s[31:0];
            end
        end
    endtask

    task automatic check1(input string what, input string tag,
                          input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s %s: got %h want %h", tag, what, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check1("bbus_in", e.tag, bbus_in, e.rd);
                check1("bbus_hit", e.tag, {31'd0, bbus_hit}, {31'd0, e.hit});
                check1("reg_valid", e.tag, {28'd0, reg_valid}, {28'd0, e.valid});
                check1("inc_wrap", e.tag, {31'd0, inc_wrap}, {31'd0, e.wrap});
            end
        end
    end

    initial begin : stim
        int k;
        logic [31:0] d;
        reset = 1'b1;
        cbus_out = '0; cbus_en = '0; bbus_en = '0;
        inc_en = 1'b0; inc_sel = '0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        mv = '0; mw = 1'b0;

        cycle(1, 0, 0, 0, 4, 0, 0, "rst0");
        cycle(0, 0, 4, 32'hDEADBEEF, 4, 0, 0, "wr4");
        cycle(0, 0, 7, 32'h12345678, 4, 0, 0, "wr7");
        cycle(0, 0, 0, 0, 4, 0, 0, "rd4");
        cycle(0, 0, 0, 0, 7, 0, 0, "rd7");
        cycle(0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, "rd0");
        cycle(0, 0, 5, 32'hFFFFFFFE, 5, 0, 0, "wr5");
        cycle(0, 0, 0, 0, 5, 1, 1, "inc1a");
        cycle(0, 0, 0, 0, 5, 1, 1, "inc1b");
        cycle(0, 0, 0, 0, 5, 0, 0, "wrap1");
        cycle(0, 0, 0, 0, 5, 0, 0, "wrap0");
        cycle(0, 0, 5, 32'hA5, 5, 1, 1, "coll");
        cycle(0, 0, 6, 32'd7, 5, 0, 0, "wr6");
        cycle(0, 0, 5, 32'hA5, 6, 1, 2, "split");
        cycle(0, 0, 3, 32'h1111, 5, 0, 0, "split_r1");
        cycle(0, 0, 8, 32'h2222, 6, 1, 4, "oor_a");
        cycle(0, 0, 15, 32'h3333, 4, 1, 7, "oor_b");
        cycle(0, 0, 0, 0, 7, 1, 5, "oor_c");
        cycle(0, 0, 0, 0, 5, 0, 0, "oor_d");
        for (int c = 0; c < 8; c++)
            cycle(1, 0, 4, 32'h5A5A5A5A, 3'(c), 1, 0, "rst_all");
        cycle(0, 0, 4, 32'h100, 4, 0, 0, "mid_wr");
        cycle(0, 0, 0, 0, 4, 1, 0, "mid_inc");
        cycle(0, 0, 0, 0, 4, 1, 0, "mid_inc");
        cycle(1, 1, 0, 0, 4, 1, 0, "mid_rst");
        cycle(0, 0, 0, 0, 4, 1, 0, "mid_resume");
        cycle(0, 0, 0, 0, 4, 0, 0, "mid_after");

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 3);
            d = (k == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom;
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), d, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)), "rand");
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clock);
        #4;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_reg_bank.md
Name: bus_reg_bank

Overview:
- Parametrised bank of NUM_REGS general-purpose datapath registers for the downsampling processor.
- Written from the C-bus by decoded write-enable codes and read onto the B-bus by decoded read-enable codes.
- Adds per-register increment (pointer/counter mode), first-write valid tracking, wrap detection and asynchronous reset.
- Sits between the ALU result bus (C-bus) and the ALU operand bus (B-bus); driven by the control unit's enable codes.

Parameters:
- WIDTH, 32, data width of each register and of both buses.
- NUM_REGS, 4, number of registers in the bank (1..16).
- CW, 4, width of cbus_en.
- BW, 3, width of bbus_en.
- CBUS_BASE, 4, cbus_en code that writes register 0; register i is written by code CBUS_BASE+i.
- BBUS_BASE, 4, bbus_en code that reads register 0; register i is read by code BBUS_BASE+i.
- SEL_W, 2, width of inc_sel; must satisfy 2^SEL_W >= NUM_REGS.
- STEP, 1, increment amount applied by inc_en.
- Legality: CBUS_BASE+NUM_REGS-1 < 2^CW and BBUS_BASE+NUM_REGS-1 < 2^BW; otherwise elaboration error.

Ports:
- clock  input  1  system clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-high reset.
- cbus_out  input  WIDTH  C-bus data to be written.
- cbus_en  input  CW  C-bus write-enable code.
- bbus_en  input  BW  B-bus read-enable code.
- inc_en  input  1  increment request for the register selected by inc_sel.
- inc_sel  input  SEL_W  index of the register to increment.
- bbus_in  output  WIDTH  B-bus data from the selected register.
- bbus_hit  output  1  high when bbus_en decodes to a register in this bank.
- reg_valid  output  NUM_REGS  bit i set once register i has been written since reset.
- inc_wrap  output  1  one-cycle flag: the last increment wrapped past 2^WIDTH-1.

Behaviour:
- Reset: this block uses one clock, `clock`, and an asynchronous, active-high reset, `reset`. While reset is high, all registers = 0, reg_valid = 0 and inc_wrap = 0, immediately and without a clock edge. Consequently bbus_in = 0 during reset.
- Write decode: on the falling edge of clock, if cbus_en == CBUS_BASE+i for i in 0..NUM_REGS-1:
  - reg[i] <= cbus_out;
  - reg_valid[i] <= 1.
  - Any other code, including 0 and codes >= CBUS_BASE+NUM_REGS, writes nothing.
- Increment: on the falling edge of clock, if inc_en = 1 and inc_sel < NUM_REGS:
  - reg[inc_sel] <= (reg[inc_sel] + STEP) mod 2^WIDTH;
  - reg_valid is unchanged by increments.
  - If inc_sel >= NUM_REGS, the increment is ignored.
- Write/increment collision on the same register in the same edge: the C-bus write wins, the increment is dropped, and inc_wrap <= 0.
- Write and increment to different registers in the same edge: both take effect.
- inc_wrap: updated every falling edge.
  - Set to 1 if an increment took effect and the unrounded sum >= 2^WIDTH.
  - Otherwise 0, so it is high for exactly one clock period per wrap.
- Read: combinational.
  - If bbus_en == BBUS_BASE+i, then bbus_in = reg[i] and bbus_hit = 1.
  - Otherwise bbus_in = 0 and bbus_hit = 0, so the bank can be OR-combined onto a shared B-bus.
- Read-during-write: bbus_in shows the old value until the falling edge, then the new value. There is no write-through bypass.
- Latency: a write or increment is visible on bbus_in immediately after the falling edge on which it is performed.
- Reset mid-operation: asserting reset during any edge overrides the write and the increment. After reset deasserts, the first falling edge behaves normally.
- No internal state machine beyond per-register state.

Test Plan:
- Reset: assert reset with no clock, reg contents nonzero -> bbus_in = 0 for every bbus_en code; reg_valid = 0; inc_wrap = 0.
- Write/read: write 0xDEADBEEF with cbus_en=4 and 0x12345678 with cbus_en=7 -> bbus_en=4 gives 0xDEADBEEF with bbus_hit=1; bbus_en=7 gives 0x12345678; reg_valid = 4'b1001; bbus_en=0 gives bbus_in=0 with bbus_hit=0.
- Increment wrap: write 0xFFFFFFFE to reg1, then inc_en=1 with inc_sel=1 for 2 edges -> reg1 = 0xFFFFFFFF then 0x00000000; inc_wrap is 0 after the first edge and 1 for exactly one cycle after the second.
- Collision: same edge with cbus_en=5, cbus_out=0xA5, inc_en=1 and inc_sel=1 -> reg1 = 0xA5 and inc_wrap = 0. Repeat with inc_sel=2 while reg2=7 -> reg1 = 0xA5 and reg2 = 8.
- Out-of-range: cbus_en=3, cbus_en=8 and cbus_en=15, plus inc_sel beyond NUM_REGS when NUM_REGS=3 -> no register changes; reg_valid unchanged.
- Reset mid-run: pulse reset between clock edges while incrementing reg0 -> reg0 clears immediately; increments resume from 0 (gives 1) on the next falling edge after deassertion.
